// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I execute-stage ALU.
package alu_pkg;

  localparam int DW_DEFAULT = 32;

  // Operation select, matching the RV32I funct3 encoding.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SR   = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_new_comb.sv
// Combinational operation mux of the ALU; func7_5 only matters for ADD/SUB and SRL/SRA.
module alu_new_comb
  import alu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          i_func7_5,
  input  logic [DW-1:0] i_op_a,
  input  logic [DW-1:0] i_op_b,
  input  logic [2:0]    i_ctl,
  output logic [DW-1:0] o_result
);

  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] w_sh;
  assign w_sh = i_op_b[SHW-1:0];

  // Select the result for the current funct3 encoding.
  always_comb begin
    o_result = {DW{1'b0}};
    case (i_ctl)
      ALU_ADD: begin
        if (i_func7_5) begin
          o_result = i_op_a - i_op_b;
        end else begin
          o_result = i_op_a + i_op_b;
        end
      end
      ALU_SLL:  o_result = i_op_a << w_sh;
      ALU_SLT:  o_result = {{(DW-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      ALU_SLTU: o_result = {{(DW-1){1'b0}}, (i_op_a < i_op_b)};
      ALU_XOR:  o_result = i_op_a ^ i_op_b;
      ALU_SR: begin
        if (i_func7_5) begin
          o_result = $unsigned($signed(i_op_a) >>> w_sh);
        end else begin
          o_result = i_op_a >> w_sh;
        end
      end
      ALU_OR:   o_result = i_op_a | i_op_b;
      ALU_AND:  o_result = i_op_a & i_op_b;
      default:  o_result = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_new.sv
// RV32I execute-stage ALU: combinational op mux followed by an async-cleared result
// register, giving one cycle of latency into writeback.
module alu_new
  import alu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          func7_5,
  input  logic [DW-1:0] alu_operand_1_i,
  input  logic [DW-1:0] alu_operand_2_i,
  input  logic [2:0]    alu_control,
  output logic [DW-1:0] alu_result_o
);

  logic [DW-1:0] w_result;
  logic [DW-1:0] r_result;

  alu_new_comb #(
    .DW (DW)
  ) u_comb (
    .i_func7_5 (func7_5),
    .i_op_a    (alu_operand_1_i),
    .i_op_b    (alu_operand_2_i),
    .i_ctl     (alu_control),
    .o_result  (w_result)
  );

  // Result register; a new operation is captured every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= {DW{1'b0}};
    end else begin
      r_result <= w_result;
    end
  end

  assign alu_result_o = r_result;

endmodule

// File: tb/tb_alu_new.sv
// Directed bench for alu_new: expected results are queued when inputs are driven and
// compared one clock later when the registered result appears.
module tb_alu_new;

  logic        clk;
  logic        rst_n;
  logic        func7_5;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  ctl;
  logic [31:0] result;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_new #(.DW(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .func7_5         (func7_5),
    .alu_operand_1_i (op_a),
    .alu_operand_2_i (op_b),
    .alu_control     (ctl),
    .alu_result_o    (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one operation, queue its expected value, then compare after the capturing edge.
  task automatic op(input string tag, input logic f7, input logic [2:0] c,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    func7_5 = f7;
    ctl     = c;
    op_a    = a;
    op_b    = b;
    e.exp   = exp;
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, result, e.exp);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    func7_5 = 1'b0;
    ctl     = 3'd0;
    op_a    = 32'd34;
    op_b    = 32'd3;

    // Load a nonzero result, then assert reset between edges.
    @(posedge clk);
    #1;
    check("pre_reset_add", result, 32'd37);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", result, 32'd0);
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h1234_5678;
    ctl  = 3'd6;
    @(posedge clk);
    #1;
    check("reset_held", result, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("after_release", result, 32'd0);
    @(posedge clk);
    #1;
    check("first_after_release", result, 32'hDEAD_BEEF | 32'h1234_5678);

    op("add",       1'b0, 3'd0, 32'd34, 32'd3, 32'd37);
    op("sll",       1'b0, 3'd1, 32'd34, 32'd3, 32'd272);
    op("slt",       1'b0, 3'd2, 32'd34, 32'd3, 32'd0);
    op("sltu",      1'b0, 3'd3, 32'd34, 32'd3, 32'd0);
    op("xor",       1'b0, 3'd4, 32'd34, 32'd3, 32'd33);
    op("srl",       1'b0, 3'd5, 32'd34, 32'd3, 32'd4);
    op("sub",       1'b1, 3'd0, 32'd34, 32'd3, 32'd31);
    op("sub_neg",   1'b1, 3'd0, 32'd3, 32'd34, 32'hFFFF_FFE1);
    op("sra_23_4",  1'b1, 3'd5, 32'd23, 32'd4, 32'd1);
    op("sra_100_5", 1'b1, 3'd5, 32'd100, 32'd5, 32'd3);
    op("sra_1111",  1'b1, 3'd5, 32'd1111, 32'd2, 32'd277);
    op("sra_9999",  1'b1, 3'd5, 32'd9999, 32'd1, 32'd4999);
    op("sra_neg",   1'b1, 3'd5, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFFC);
    op("srl_neg",   1'b0, 3'd5, 32'hFFFF_FFF0, 32'd2, 32'h3FFF_FFFC);
    op("or",        1'b0, 3'd6, 32'd101010, 32'd3, 32'd101011);
    op("and",       1'b0, 3'd7, 32'd101010, 32'd3, 32'd2);
    op("or_f7",     1'b1, 3'd6, 32'd101010, 32'd3, 32'd101011);
    op("and_f7",    1'b1, 3'd7, 32'd101010, 32'd3, 32'd2);
    op("xor_f7",    1'b1, 3'd4, 32'd34, 32'd3, 32'd33);
    op("sll_f7",    1'b1, 3'd1, 32'd34, 32'd3, 32'd272);
    op("slt_signed",  1'b0, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op("sltu_signed", 1'b0, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
    op("slt_f7",      1'b1, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op("slt_eq",    1'b0, 3'd2, 32'h8000_0001, 32'h8000_0001, 32'd0);
    op("sltu_eq",   1'b0, 3'd3, 32'h8000_0001, 32'h8000_0001, 32'd0);
    op("sltu_lt",   1'b0, 3'd3, 32'd1, 32'hFFFF_FFFF, 32'd1);
    op("sll_mask",  1'b0, 3'd1, 32'd1, 32'h0000_0021, 32'd2);
    op("sll_zero",  1'b0, 3'd1, 32'd1, 32'd0, 32'd1);
    op("sra_zero",  1'b1, 3'd5, 32'h8000_0005, 32'h0000_0020, 32'h8000_0005);
    op("sll_31",    1'b0, 3'd1, 32'd3, 32'd31, 32'h8000_0000);
    op("sra_31",    1'b1, 3'd5, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    op("add_wrap",  1'b0, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
